// File: rtl/fpu_float_to_int_pkg.sv
//==============================================================================
// Module   : fpu_float_to_int_pkg
// Brief    : Shared constants, float layout, status indices and FSM encoding
//            for the float-to-integer converter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package fpu_float_to_int_pkg;

   localparam int EXP_W   = 6;
   localparam int MANT_W  = 25;
   localparam int INT_W   = 32;
   localparam int BIAS    = (2 ** (EXP_W - 1)) - 1;
   localparam int FLOAT_W = 1 + EXP_W + MANT_W;
   localparam int STAT_W  = 4;
   localparam int CNT_W   = EXP_W;

   localparam int ST_EXACT     = 3;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_UNDERFLOW = 1;
   localparam int ST_INEXACT   = 0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] frac;
   } float_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIGN = 2'd1,
      S_PACK  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_float_to_int_if.sv
//==============================================================================
// Module   : fpu_float_to_int_if
// Brief    : Operand/result valid-ready bundle between producer, converter
//            and consumer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fpu_float_to_int_if;
   import fpu_float_to_int_pkg::*;

   logic [FLOAT_W-1:0] op_in;
   logic               in_valid;
   logic               in_ready;
   logic [INT_W-1:0]   data_out;
   logic [STAT_W-1:0]  status_out;
   logic               out_valid;
   logic               out_ready;

   modport slave (
      input  op_in, in_valid, out_ready,
      output in_ready, data_out, status_out, out_valid
   );

   modport master (
      output op_in, in_valid, out_ready,
      input  in_ready, data_out, status_out, out_valid
   );

endinterface

`default_nettype wire

// File: rtl/fpu_float_to_int.sv
//==============================================================================
// Module   : fpu_float_to_int
// Brief    : Multi-cycle custom-float to 32-bit integer converter, truncating
//            toward zero, one alignment shift per clock.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fpu_float_to_int
   import fpu_float_to_int_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   fpu_float_to_int_if.slave  bus
);

   localparam logic [EXP_W-1:0] c_bias     = EXP_W'(BIAS);
   localparam logic [EXP_W-1:0] c_exp_top  = EXP_W'(2 * BIAS);
   localparam logic [EXP_W-1:0] c_mant_w   = EXP_W'(MANT_W);
   localparam logic [INT_W-1:0] c_sat_pos  = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] c_sat_neg  = {1'b1, {(INT_W-1){1'b0}}};

   state_t              r_state;
   logic [INT_W-1:0]    r_mag;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_left;
   logic                r_sign;
   logic                r_sticky;
   logic                r_ovf;
   logic                r_unf;
   logic [INT_W-1:0]    r_data;
   logic [STAT_W-1:0]   r_status;
   logic                r_out_valid;
   logic                r_in_ready;

   float_t              w_op;
   logic                w_frac_zero;
   logic                w_is_zero;
   logic                w_is_unf;
   logic                w_is_sat;
   logic [EXP_W-1:0]    w_e;
   logic                w_left;
   logic [CNT_W-1:0]    w_k;
   logic [INT_W-1:0]    w_sig;
   logic                w_inexact;
   logic [INT_W-1:0]    w_pack_data;
   logic [STAT_W-1:0]   w_pack_status;

   assign w_op        = bus.op_in;
   assign w_frac_zero = (w_op.frac == '0);
   assign w_is_zero   = (w_op.exp == '0);
   assign w_is_unf    = !w_is_zero && (w_op.exp < c_bias);
   // E==31 only fits when the result is exactly -2**31.
   assign w_is_sat    = (w_op.exp > c_exp_top) ||
                        ((w_op.exp == c_exp_top) && !(w_op.sign && w_frac_zero));

   // Unbiased exponent is only meaningful for the normal class (E in 0..31).
   assign w_e    = w_op.exp - c_bias;
   assign w_left = (w_e > c_mant_w);
   assign w_k    = w_left ? (w_e - c_mant_w) : (c_mant_w - w_e);
   assign w_sig  = {{(INT_W-MANT_W-1){1'b0}}, 1'b1, w_op.frac};

   assign w_inexact   = r_sticky | r_ovf | r_unf;
   assign w_pack_data = r_sign ? (~r_mag + INT_W'(1)) : r_mag;

   always_comb begin
      w_pack_status               = '0;
      w_pack_status[ST_EXACT]     = !w_inexact;
      w_pack_status[ST_OVERFLOW]  = r_ovf;
      w_pack_status[ST_UNDERFLOW] = r_unf;
      w_pack_status[ST_INEXACT]   = w_inexact;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_mag       <= '0;
         r_cnt       <= '0;
         r_left      <= 1'b0;
         r_sign      <= 1'b0;
         r_sticky    <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_data      <= '0;
         r_status    <= '0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_sign     <= w_op.sign;
                  r_left     <= w_left;
                  r_cnt      <= w_k;
                  r_sticky   <= 1'b0;
                  r_ovf      <= 1'b0;
                  r_unf      <= 1'b0;
                  r_state    <= S_PACK;
                  if (w_is_zero) begin
                     r_mag    <= '0;
                     r_unf    <= !w_frac_zero;
                     r_sticky <= !w_frac_zero;
                  end else if (w_is_unf) begin
                     r_mag    <= '0;
                     r_unf    <= 1'b1;
                     r_sticky <= 1'b1;
                  end else if (w_is_sat) begin
                     r_mag    <= w_op.sign ? c_sat_neg : c_sat_pos;
                     r_ovf    <= 1'b1;
                     r_sticky <= 1'b1;
                  end else begin
                     r_mag <= w_sig;
                     if (w_k != '0) begin
                        r_state <= S_ALIGN;
                     end
                  end
               end
            end
            S_ALIGN: begin
               if (r_left) begin
                  r_mag <= r_mag << 1;
               end else begin
                  r_mag    <= r_mag >> 1;
                  r_sticky <= r_sticky | r_mag[0];
               end
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= S_PACK;
               end
            end
            S_PACK: begin
               r_data   <= w_pack_data;
               r_status <= w_pack_status;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               if (r_out_valid && bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.data_out   = r_data;
   assign bus.status_out = r_status;
   assign bus.out_valid  = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_fpu_float_to_int.sv
//==============================================================================
// Module   : tb_fpu_float_to_int
// Brief    : Directed self-checking bench for the float-to-integer converter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fpu_float_to_int;
   import fpu_float_to_int_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   fpu_float_to_int_if bus ();

   fpu_float_to_int dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Issues one operand and completes the result handshake; latency counts
   // edges from the accept edge to the edge that raises out_valid.
   task automatic do_op(input logic [31:0] op, output logic [31:0] d,
                        output logic [3:0] s, output int lat);
      bus.op_in    = op;
      bus.in_valid = 1'b1;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      d = bus.data_out;
      s = bus.status_out;
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.op_in     = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      reset         = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      end
      checks++;
      if (bus.data_out !== 32'h0) begin
         failures++; $display("FAIL reset_data got=%h want=00000000", bus.data_out);
      end
      checks++;
      if (bus.status_out !== 4'b0000) begin
         failures++; $display("FAIL reset_status got=%b want=0000", bus.status_out);
      end
      #1 reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      end
   endtask

   task automatic test_table(input string tag, input logic [31:0] ops [],
                             input logic [31:0] exp_d [], input logic [3:0] exp_s [],
                             input int exp_lat []);
      logic [31:0] d;
      logic [3:0]  s;
      int          lat;
      for (int i = 0; i < ops.size(); i++) begin
         do_op(ops[i], d, s, lat);
         checks++;
         if (d !== exp_d[i]) begin
            failures++;
            $display("FAIL %s_data[%0d] op=%h got=%h want=%h", tag, i, ops[i], d, exp_d[i]);
         end
         checks++;
         if (s !== exp_s[i]) begin
            failures++;
            $display("FAIL %s_status[%0d] op=%h got=%b want=%b", tag, i, ops[i], s, exp_s[i]);
         end
         checks++;
         if (lat !== exp_lat[i]) begin
            failures++;
            $display("FAIL %s_latency[%0d] op=%h got=%0d want=%0d", tag, i, ops[i], lat, exp_lat[i]);
         end
      end
   endtask

   task automatic test_normal();
      logic [31:0] ops [] = '{32'hC000_0000, 32'h3F00_0000, 32'h4280_0000,
                              32'hC1C0_0000, 32'h7600_0000, 32'h7000_0001,
                              32'hFC00_0000};
      logic [31:0] dd  [] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0005,
                              32'hFFFF_FFFD, 32'h1000_0000, 32'h0200_0001,
                              32'h8000_0000};
      logic [3:0]  ss  [] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000,
                              4'b1000, 4'b1000};
      int          ll  [] = '{26, 27, 25, 26, 5, 2, 8};
      test_table("normal", ops, dd, ss, ll);
   endtask

   task automatic test_specials();
      logic [31:0] ops [] = '{32'h3C00_0000, 32'h0000_0002, 32'h7F00_0000,
                              32'h7C00_0000, 32'h0000_0000, 32'h8000_0005,
                              32'hFE00_0000};
      logic [31:0] dd  [] = '{32'h0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                              32'h0, 32'h0, 32'h8000_0000};
      logic [3:0]  ss  [] = '{4'b0011, 4'b0011, 4'b0101, 4'b0101, 4'b1000,
                              4'b0011, 4'b0101};
      int          ll  [] = '{2, 2, 2, 2, 2, 2, 2};
      test_table("special", ops, dd, ss, ll);
   endtask

   task automatic test_backpressure();
      int n = 0;
      bus.op_in    = 32'h7000_0001;
      bus.in_valid = 1'b1;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++; $display("FAIL bp_wait got=%b want=1", bus.out_valid);
      end
      bus.op_in    = 32'h3F00_0000;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h0200_0001 ||
             bus.status_out !== 4'b1000 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold[%0d] got v=%b d=%h s=%b rdy=%b want v=1 d=02000001 s=1000 rdy=0",
                     c, bus.out_valid, bus.data_out, bus.status_out, bus.in_ready);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_ignored got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid_align();
      logic [31:0] d;
      logic [3:0]  s;
      int          lat;
      bus.op_in    = 32'h3F00_0000;
      bus.in_valid = 1'b1;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.data_out !== 32'h0 || bus.status_out !== 4'b0) begin
         failures++;
         $display("FAIL midreset_clear got v=%b d=%h s=%b want v=0 d=00000000 s=0000",
                  bus.out_valid, bus.data_out, bus.status_out);
      end
      @(posedge clock);
      #3 reset = 1'b1;
      @(posedge clock); #1;
      do_op(32'hC000_0000, d, s, lat);
      checks++;
      if (d !== 32'hFFFF_FFFE || s !== 4'b1000 || lat !== 26) begin
         failures++;
         $display("FAIL midreset_next got d=%h s=%b lat=%0d want d=fffffffe s=1000 lat=26",
                  d, s, lat);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_specials();
      test_backpressure();
      test_reset_mid_align();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
